// File: rtl/dma_burst_scheduler_pkg.sv
// Shared definitions for the DMA burst scheduler: FSM encodings, page
// geometry, priority width and the page-remaining helper.
package dma_burst_scheduler_pkg;

  // FSM encodings (plain constants so they read the same in every tool)
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARB    = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_UPDATE = 3'd4;

  // AXI bursts must not cross a 4 KB page
  localparam int PAGE_BYTES = 4096;
  localparam int PAGE_OFF_W = 12;

  // Channel priority width; 3 is the most urgent
  localparam int PRIO_W = 2;

  // Bytes left before the next page boundary, given the in-page offset.
  // Result is in 1..4096, so it needs one bit more than the offset.
  function automatic logic [PAGE_OFF_W:0] page_left(input logic [PAGE_OFF_W-1:0] off);
    page_left = (PAGE_OFF_W+1)'(PAGE_BYTES) - {1'b0, off};
  endfunction

endpackage

// File: rtl/dma_burst_scheduler_if.sv
// Scheduler <-> transfer engine burst interface.
//
// Handshake: the scheduler raises eng_start for exactly one cycle with
// eng_src_addr/eng_dst_addr/eng_size/eng_channel valid in that cycle; those
// fields then hold until the scheduler launches its next burst. The engine
// owns exactly one burst at a time and ends it with a one-cycle eng_done or
// eng_error pulse (eng_error wins if both are seen together). There is no
// back-pressure on eng_start: the scheduler never launches a second burst
// before the first has ended.
interface dma_burst_scheduler_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int CH_ID_WIDTH = 2
);
  logic                   eng_start;
  logic [ADDR_WIDTH-1:0]  eng_src_addr;
  logic [ADDR_WIDTH-1:0]  eng_dst_addr;
  logic [ADDR_WIDTH-1:0]  eng_size;
  logic [CH_ID_WIDTH-1:0] eng_channel;
  logic                   eng_done;
  logic                   eng_error;

  modport master (
    output eng_start, eng_src_addr, eng_dst_addr, eng_size, eng_channel,
    input  eng_done, eng_error
  );

  modport slave (
    input  eng_start, eng_src_addr, eng_dst_addr, eng_size, eng_channel,
    output eng_done, eng_error
  );
endinterface

// File: rtl/dma_burst_scheduler_rr_prio_picker.sv
// Combinational picker: highest priority among eligible channels, ties
// broken round-robin starting strictly after the pointer and wrapping.
module dma_rr_prio_picker
  import dma_burst_scheduler_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int CH_ID_WIDTH  = 2
) (
  input  logic [NUM_CHANNELS-1:0]        eligible,
  input  logic [NUM_CHANNELS*PRIO_W-1:0] prio,
  input  logic [CH_ID_WIDTH-1:0]         ptr,
  output logic [CH_ID_WIDTH-1:0]         grant,
  output logic                           valid
);

  logic [PRIO_W-1:0]      prio_a [NUM_CHANNELS];
  logic [PRIO_W-1:0]      best_prio;
  logic [CH_ID_WIDTH-1:0] idx;
  int                     idx_i;

  // Unpack the flat priority bus into per-channel entries
  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      prio_a[i] = prio[i*PRIO_W +: PRIO_W];
    end
  end

  // Scan in round-robin order; only a strictly higher priority displaces the
  // current pick, so the first eligible channel after ptr wins ties
  always_comb begin
    grant     = '0;
    valid     = 1'b0;
    best_prio = '0;
    idx_i     = 0;
    idx       = '0;
    for (int k = 1; k <= NUM_CHANNELS; k++) begin
      idx_i = (int'(ptr) + k) % NUM_CHANNELS;
      idx   = CH_ID_WIDTH'(idx_i);
      if (eligible[idx] && (!valid || (prio_a[idx] > best_prio))) begin
        valid     = 1'b1;
        grant     = idx;
        best_prio = prio_a[idx];
      end
    end
  end

endmodule

// File: rtl/dma_burst_scheduler.sv
// DMA burst scheduler: cuts each channel's transfer into page-safe bursts
// no larger than MAX_BURST_BYTES and time-shares one transfer engine between
// channels burst by burst (strict priority, round-robin within a priority).
module dma_burst_scheduler
  import dma_burst_scheduler_pkg::*;
#(
  parameter int NUM_CHANNELS    = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_BURST_BYTES = 64,
  parameter int CH_ID_WIDTH     = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_CHANNELS-1:0]          ch_start,
  input  logic [NUM_CHANNELS-1:0]          ch_abort,
  input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] ch_src_addr,
  input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] ch_dst_addr,
  input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] ch_length,
  input  logic [NUM_CHANNELS*PRIO_W-1:0]   ch_priority,
  output logic [NUM_CHANNELS-1:0]          ch_busy,
  output logic [NUM_CHANNELS-1:0]          ch_done,
  output logic [NUM_CHANNELS-1:0]          ch_error,
  output logic [NUM_CHANNELS*ADDR_WIDTH-1:0] ch_remaining,
  output logic [2:0]                       dbg_state,
  dma_burst_scheduler_if.master            eng
);

  typedef logic [ADDR_WIDTH-1:0] addr_t;

  localparam addr_t LEN_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
  localparam addr_t MAX_BURST = ADDR_WIDTH'(MAX_BURST_BYTES);

  // Per-channel progress
  addr_t cur_src_q [NUM_CHANNELS];
  addr_t cur_src_d [NUM_CHANNELS];
  addr_t cur_dst_q [NUM_CHANNELS];
  addr_t cur_dst_d [NUM_CHANNELS];
  addr_t rem_q     [NUM_CHANNELS];
  addr_t rem_d     [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] busy_q, busy_d;
  logic [NUM_CHANNELS-1:0] done_q, done_d;
  logic [NUM_CHANNELS-1:0] error_q, error_d;

  // Scheduler state
  logic [2:0]             state_q, state_d;
  logic [CH_ID_WIDTH-1:0] active_q, active_d;
  logic [CH_ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic                   abort_pend_q, abort_pend_d;
  logic                   eng_start_q, eng_start_d;
  addr_t                  eng_src_q, eng_src_d;
  addr_t                  eng_dst_q, eng_dst_d;
  addr_t                  eng_size_q, eng_size_d;

  // Arbitration helpers
  logic [NUM_CHANNELS-1:0] eligible;
  logic [NUM_CHANNELS-1:0] arb_mask;
  logic [CH_ID_WIDTH-1:0]  grant;
  logic                    pick_valid;
  addr_t                   win_src, win_dst, win_rem;
  addr_t                   src_left, dst_left, chunk;
  logic                    in_flight;
  logic                    any_next;

  // A channel competes while it is loaded and still has bytes to move; a
  // channel being aborted this very cycle is kept out of the arbitration
  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      eligible[i] = busy_q[i] && (rem_q[i] != '0);
    end
    arb_mask = eligible & ~ch_abort;
  end

  dma_rr_prio_picker #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .CH_ID_WIDTH  (CH_ID_WIDTH)
  ) u_picker (
    .eligible (arb_mask),
    .prio     (ch_priority),
    .ptr      (rr_ptr_q),
    .grant    (grant),
    .valid    (pick_valid)
  );

  // Winner's burst size: remaining bytes, clipped to the burst limit and to
  // whichever of the source or destination page ends first
  always_comb begin
    win_src  = cur_src_q[grant];
    win_dst  = cur_dst_q[grant];
    win_rem  = rem_q[grant];
    src_left = ADDR_WIDTH'(page_left(win_src[PAGE_OFF_W-1:0]));
    dst_left = ADDR_WIDTH'(page_left(win_dst[PAGE_OFF_W-1:0]));
    chunk    = win_rem;
    if (MAX_BURST < chunk) chunk = MAX_BURST;
    if (src_left < chunk)  chunk = src_left;
    if (dst_left < chunk)  chunk = dst_left;
  end

  // The active channel owns the engine while its burst is launched or running
  assign in_flight = (state_q == S_ISSUE) || (state_q == S_WAIT);

  // Next-state logic: channel load/abort first, then the burst FSM
  always_comb begin
    state_d      = state_q;
    active_d     = active_q;
    rr_ptr_d     = rr_ptr_q;
    abort_pend_d = abort_pend_q;
    eng_start_d  = 1'b0;
    eng_src_d    = eng_src_q;
    eng_dst_d    = eng_dst_q;
    eng_size_d   = eng_size_q;
    busy_d       = busy_q;
    done_d       = '0;
    error_d      = '0;
    any_next     = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      cur_src_d[i] = cur_src_q[i];
      cur_dst_d[i] = cur_dst_q[i];
      rem_d[i]     = rem_q[i];
    end

    // Abort beats start. Aborting the running channel only arms a flag so the
    // engine's burst finishes cleanly; other channels drop out immediately.
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (ch_abort[i]) begin
        if (in_flight && (active_q == CH_ID_WIDTH'(i))) begin
          abort_pend_d = 1'b1;
        end else begin
          busy_d[i] = 1'b0;
        end
      end else if (ch_start[i] && !busy_q[i]) begin
        cur_src_d[i] = ch_src_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        cur_dst_d[i] = ch_dst_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        rem_d[i]     = ch_length[i*ADDR_WIDTH +: ADDR_WIDTH] & LEN_MASK;
        if ((ch_length[i*ADDR_WIDTH +: ADDR_WIDTH] & LEN_MASK) == '0) begin
          done_d[i] = 1'b1;
        end else begin
          busy_d[i] = 1'b1;
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (|eligible) state_d = S_ARB;
      end
      S_ARB: begin
        if (pick_valid) begin
          active_d     = grant;
          eng_src_d    = win_src;
          eng_dst_d    = win_dst;
          eng_size_d   = chunk;
          eng_start_d  = 1'b1;
          abort_pend_d = 1'b0;
          state_d      = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (eng.eng_error) begin
          error_d[active_q] = 1'b1;
          busy_d[active_q]  = 1'b0;
          abort_pend_d      = 1'b0;
          state_d           = S_IDLE;
        end else if (eng.eng_done) begin
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        cur_src_d[active_q] = cur_src_q[active_q] + eng_size_q;
        cur_dst_d[active_q] = cur_dst_q[active_q] + eng_size_q;
        rem_d[active_q]     = rem_q[active_q] - eng_size_q;
        rr_ptr_d            = active_q;
        abort_pend_d        = 1'b0;
        if (abort_pend_q || ch_abort[active_q]) begin
          busy_d[active_q] = 1'b0;
        end else if (rem_d[active_q] == '0) begin
          done_d[active_q] = 1'b1;
          busy_d[active_q] = 1'b0;
        end
        for (int i = 0; i < NUM_CHANNELS; i++) begin
          if (busy_d[i] && (rem_d[i] != '0)) any_next = 1'b1;
        end
        state_d = any_next ? S_ARB : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset also clears any burst in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      active_q     <= '0;
      rr_ptr_q     <= CH_ID_WIDTH'(NUM_CHANNELS - 1);
      abort_pend_q <= 1'b0;
      eng_start_q  <= 1'b0;
      eng_src_q    <= '0;
      eng_dst_q    <= '0;
      eng_size_q   <= '0;
      busy_q       <= '0;
      done_q       <= '0;
      error_q      <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        cur_src_q[i] <= '0;
        cur_dst_q[i] <= '0;
        rem_q[i]     <= '0;
      end
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      rr_ptr_q     <= rr_ptr_d;
      abort_pend_q <= abort_pend_d;
      eng_start_q  <= eng_start_d;
      eng_src_q    <= eng_src_d;
      eng_dst_q    <= eng_dst_d;
      eng_size_q   <= eng_size_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        cur_src_q[i] <= cur_src_d[i];
        cur_dst_q[i] <= cur_dst_d[i];
        rem_q[i]     <= rem_d[i];
      end
    end
  end

  // Output mapping
  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      ch_remaining[i*ADDR_WIDTH +: ADDR_WIDTH] = rem_q[i];
    end
  end

  assign ch_busy          = busy_q;
  assign ch_done          = done_q;
  assign ch_error         = error_q;
  assign dbg_state        = state_q;
  assign eng.eng_start    = eng_start_q;
  assign eng.eng_src_addr = eng_src_q;
  assign eng.eng_dst_addr = eng_dst_q;
  assign eng.eng_size     = eng_size_q;
  assign eng.eng_channel  = active_q;

endmodule

// File: tb/tb_dma_burst_scheduler.sv
// Directed bench for dma_burst_scheduler: expected bursts, done and error
// events are queued by the stimulus and checked by an independent monitor.
module tb_dma_burst_scheduler;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int CW = 2;
  localparam int BW = CW + 3*AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    ch_start, ch_abort;
  logic [N*AW-1:0] ch_src_addr, ch_dst_addr, ch_length;
  logic [N*2-1:0]  ch_priority;
  logic [N-1:0]    ch_busy, ch_done, ch_error;
  logic [N*AW-1:0] ch_remaining;
  logic [2:0]      dbg_state;

  dma_burst_scheduler_if #(.ADDR_WIDTH(AW), .CH_ID_WIDTH(CW)) eng ();

  dma_burst_scheduler #(
    .NUM_CHANNELS(N), .ADDR_WIDTH(AW), .MAX_BURST_BYTES(64), .CH_ID_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ch_start(ch_start), .ch_abort(ch_abort),
    .ch_src_addr(ch_src_addr), .ch_dst_addr(ch_dst_addr), .ch_length(ch_length),
    .ch_priority(ch_priority),
    .ch_busy(ch_busy), .ch_done(ch_done), .ch_error(ch_error),
    .ch_remaining(ch_remaining), .dbg_state(dbg_state),
    .eng(eng.master)
  );

  // ---------------- scoreboard ----------------
  logic [BW-1:0] exp_q[$];
  logic [CW-1:0] done_exp_q[$];
  logic [CW-1:0] err_exp_q[$];
  int chk_cnt = 0;
  int pass_cnt = 0;
  int bursts_seen = 0;
  int err_at = -1;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic flag_unexpected(input string name, input logic [BW-1:0] act);
    chk_cnt++;
    $display("FAIL %s: got %0h expected none", name, act);
  endtask

  // Monitor: every launched burst and every done/error pulse must match the
  // next expected entry
  always @(negedge clk) begin
    if (rst_n) begin
      if (eng.eng_start) begin
        if (exp_q.size() == 0)
          flag_unexpected("burst", {eng.eng_channel, eng.eng_src_addr, eng.eng_dst_addr, eng.eng_size});
        else
          check("burst", {eng.eng_channel, eng.eng_src_addr, eng.eng_dst_addr, eng.eng_size}, exp_q.pop_front());
      end
      for (int i = 0; i < N; i++) begin
        if (ch_done[i]) begin
          if (done_exp_q.size() == 0) flag_unexpected("ch_done", BW'(i));
          else check("ch_done", BW'(i), BW'(done_exp_q.pop_front()));
        end
        if (ch_error[i]) begin
          if (err_exp_q.size() == 0) flag_unexpected("ch_error", BW'(i));
          else check("ch_error", BW'(i), BW'(err_exp_q.pop_front()));
        end
      end
    end
  end

  // Engine model: finishes each burst two cycles after eng_start, or fails
  // the burst whose global index equals err_at
  initial begin
    eng.eng_done  = 1'b0;
    eng.eng_error = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && eng.eng_start) begin
        bursts_seen++;
        repeat (2) @(posedge clk);
        #1;
        if (bursts_seen == err_at) eng.eng_error = 1'b1;
        else eng.eng_done = 1'b1;
        @(posedge clk); #1;
        eng.eng_done  = 1'b0;
        eng.eng_error = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_ch(input int c, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                        input logic [AW-1:0] len, input logic [1:0] pr);
    ch_src_addr[c*AW +: AW] = src;
    ch_dst_addr[c*AW +: AW] = dst;
    ch_length[c*AW +: AW]   = len;
    ch_priority[c*2 +: 2]   = pr;
  endtask

  task automatic push_burst(input int c, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                            input logic [AW-1:0] size);
    exp_q.push_back({CW'(c), src, dst, size});
  endtask

  task automatic pulse_start(input logic [N-1:0] m);
    ch_start = m;
    step();
    ch_start = '0;
  endtask

  task automatic wait_start(input string name);
    int n = 0;
    while (!eng.eng_start && n < 200) begin step(); n++; end
    if (n >= 200) flag_unexpected({name, "_start_timeout"}, BW'(n));
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((ch_busy != '0 || exp_q.size() != 0) && n < 2000) begin step(); n++; end
    repeat (12) step();
    chk_cnt++;
    if (n < 2000 && exp_q.size() == 0 && done_exp_q.size() == 0 && err_exp_q.size() == 0)
      pass_cnt++;
    else
      $display("FAIL %s_drain: busy=%b bursts_left=%0d dones_left=%0d errors_left=%0d",
               name, ch_busy, exp_q.size(), done_exp_q.size(), err_exp_q.size());
  endtask

  function automatic logic [AW-1:0] rem_of(input int c);
    return ch_remaining[c*AW +: AW];
  endfunction

  // ---------------- directed tests ----------------
  initial begin
    ch_start = '0; ch_abort = '0;
    ch_src_addr = '0; ch_dst_addr = '0; ch_length = '0; ch_priority = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", BW'(ch_busy), '0);
    check("rst_done_err", BW'({ch_done, ch_error}), '0);
    check("rst_remaining", BW'(ch_remaining), '0);
    check("rst_eng", {eng.eng_channel, eng.eng_src_addr, eng.eng_dst_addr, eng.eng_size}, '0);
    check("rst_eng_start", BW'(eng.eng_start), '0);
    check("rst_state", BW'(dbg_state), '0);
    rst_n = 1'b1;
    step();

    // Arbitration: ch2/ch3 at priority 3 alternate, ch0 at priority 1 last
    set_ch(0, 32'h0000, 32'h8000, 128, 2'd1);
    set_ch(2, 32'h2000, 32'hA000, 128, 2'd3);
    set_ch(3, 32'h3000, 32'hB000, 128, 2'd3);
    push_burst(2, 32'h2000, 32'hA000, 64);
    push_burst(3, 32'h3000, 32'hB000, 64);
    push_burst(2, 32'h2040, 32'hA040, 64);
    push_burst(3, 32'h3040, 32'hB040, 64);
    push_burst(0, 32'h0000, 32'h8000, 64);
    push_burst(0, 32'h0040, 32'h8040, 64);
    done_exp_q.push_back(2); done_exp_q.push_back(3); done_exp_q.push_back(0);
    pulse_start(4'b1101);
    wait_idle("arb");
    check("arb_rem", BW'({rem_of(0), rem_of(2), rem_of(3)}), '0);

    // Single transfer of 200 bytes -> 64,64,64,8; a second start while busy is ignored
    set_ch(0, 32'h1000, 32'h2000, 200, 2'd0);
    push_burst(0, 32'h1000, 32'h2000, 64);
    push_burst(0, 32'h1040, 32'h2040, 64);
    push_burst(0, 32'h1080, 32'h2080, 64);
    push_burst(0, 32'h10C0, 32'h20C0, 8);
    done_exp_q.push_back(0);
    pulse_start(4'b0001);
    wait_start("single");
    set_ch(0, 32'hDEAD0000, 32'hBEEF0000, 16, 2'd0);
    pulse_start(4'b0001);
    wait_idle("single");
    check("single_rem0", BW'(rem_of(0)), '0);
    check("single_busy", BW'(ch_busy), '0);

    // Source page split: 16 bytes up to 0x1000, then 48
    set_ch(1, 32'h0FF0, 32'h5000, 64, 2'd0);
    push_burst(1, 32'h0FF0, 32'h5000, 16);
    push_burst(1, 32'h1000, 32'h5010, 48);
    done_exp_q.push_back(1);
    pulse_start(4'b0010);
    wait_idle("src_split");

    // Destination page split: 8 bytes up to 0x7000, then 8
    set_ch(2, 32'h7000, 32'h6FF8, 16, 2'd0);
    push_burst(2, 32'h7000, 32'h6FF8, 8);
    push_burst(2, 32'h7008, 32'h7000, 8);
    done_exp_q.push_back(2);
    pulse_start(4'b0100);
    wait_idle("dst_split");

    // Engine error on ch1's second burst of 256
    set_ch(1, 32'h3000, 32'h4000, 256, 2'd0);
    err_at = bursts_seen + 2;
    push_burst(1, 32'h3000, 32'h4000, 64);
    push_burst(1, 32'h3040, 32'h4040, 64);
    err_exp_q.push_back(1);
    pulse_start(4'b0010);
    wait_idle("error");
    err_at = -1;
    check("error_rem1", BW'(rem_of(1)), BW'(192));
    check("error_busy", BW'(ch_busy), '0);

    // Abort active ch0 in S_WAIT and idle-waiting ch1 in the same cycle
    set_ch(0, 32'h6000, 32'h7000, 128, 2'd3);
    set_ch(1, 32'h9000, 32'h9800, 64, 2'd0);
    push_burst(0, 32'h6000, 32'h7000, 64);
    pulse_start(4'b0011);
    wait_start("abort");
    step();
    ch_abort = 4'b0011;
    step();
    ch_abort = '0;
    wait_idle("abort");
    check("abort_rem0", BW'(rem_of(0)), BW'(64));
    check("abort_rem1", BW'(rem_of(1)), BW'(64));
    check("abort_busy", BW'(ch_busy), '0);

    // Length 3 rounds down to zero: immediate done, never busy, no burst
    set_ch(3, 32'h0100, 32'h0200, 3, 2'd0);
    done_exp_q.push_back(3);
    pulse_start(4'b1000);
    check("len3_busy", BW'(ch_busy[3]), '0);
    wait_idle("len3");
    check("len3_rem3", BW'(rem_of(3)), '0);

    // Reset while a burst is in S_WAIT clears everything at once
    set_ch(2, 32'h2000, 32'h3000, 128, 2'd0);
    push_burst(2, 32'h2000, 32'h3000, 64);
    pulse_start(4'b0100);
    wait_start("reset_mid");
    step();
    rst_n = 1'b0;
    #1;
    check("midrst_busy", BW'(ch_busy), '0);
    check("midrst_remaining", BW'(ch_remaining), '0);
    check("midrst_eng", {eng.eng_channel, eng.eng_src_addr, eng.eng_dst_addr, eng.eng_size}, '0);
    check("midrst_pulses", BW'({eng.eng_start, ch_done, ch_error}), '0);
    check("midrst_state", BW'(dbg_state), '0);
    repeat (4) step();
    rst_n = 1'b1;
    repeat (10) step();
    check("postrst_idle", BW'({ch_busy, dbg_state}), '0);
    check("postrst_queue", BW'(exp_q.size() + done_exp_q.size() + err_exp_q.size()), '0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  // Global time bound
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
